// File: rtl/chan_sel_pipe.sv
// Per-channel select/enable combine with all/any reduction flags, buffered in a
// small FIFO behind a valid/ready handshake.
module chan_sel_pipe #(
    parameter int CH    = 4,
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH-1:0]     sel,
    input  logic [CH-1:0]     en,
    input  logic [W-1:0]      data_a,
    input  logic [W-1:0]      data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*W-1:0]   out_data,
    output logic              out_all,
    output logic              out_any,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = CH * W + 2;
    localparam logic [PW-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [BW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CH*W-1:0] result;
    logic [CH-1:0]   nonzero;
    logic            all_flag;
    logic            any_flag;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [BW-1:0]   head;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign result[i*W +: W] = en[i] ? (sel[i] ? data_b : data_a) : '0;
        assign nonzero[i]       = |result[i*W +: W];
    end

    // Disabled channels count as satisfied for "all", so en==0 yields all=1.
    assign all_flag = &(nonzero | ~en);
    assign any_flag = |(nonzero & en);

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full;
    assign pop       = ~empty & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {result, all_flag, any_flag};
                wr_ptr              <= wr_ptr + PTR_ONE;
                beat_cnt            <= beat_cnt + CNT_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Outputs are forced to zero while empty so stale entries never leak out.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_data = empty ? '0   : head[BW-1:2];
    assign out_all  = empty ? 1'b0 : head[1];
    assign out_any  = empty ? 1'b0 : head[0];

endmodule
